// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg
// Shared constants for the GPIO pad controller: register indices on the
// 3-bit register bus and the reset value of the debounce divider.
// Optional feature macro used by the importing files: GPIO_PAD_DBNC_EN.
package gpio_pad_pkg;

  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_OE       = 3'd1;
  localparam logic [2:0] GPIO_IN       = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_IRQ_PEND = 3'd4;
  localparam logic [2:0] GPIO_IRQ_POL  = 3'd5;
  localparam logic [2:0] GPIO_DIV      = 3'd6;

  // DIV comes out of reset at 1 so the prescaler ticks every cycle.
  localparam int unsigned GPIO_DIV_RST = 1;

endpackage

// File: rtl/gpio_pad_dbnc.sv
// gpio_pad_dbnc
// Per-pin input conditioning: 2-flop synchronizer followed by the filtered
// value flop. With GPIO_PAD_DBNC_EN defined, a 2-bit tick history makes the
// filtered value follow the synchronized input only once it has been seen
// at the same level on three consecutive ticks; otherwise the filtered value
// is the synchronized input delayed one cycle.
// Ports:
//   clk       in   core clock
//   rst_n     in   asynchronous active-low reset
//   tick      in   shared prescaler tick (ignored without debounce)
//   din       in   raw asynchronous pad input
//   filt      out  registered filtered value
//   filt_next out  value filt takes at the next edge (for edge detection)
module gpio_pad_dbnc (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic filt,
  output logic filt_next
);

  logic sync1_reg;
  logic sync_reg;
  logic filt_reg;

`ifdef GPIO_PAD_DBNC_EN
  // hist_reg[0] is the sample from the most recent tick.
  logic [1:0] hist_reg;

  always_comb begin
    filt_next = filt_reg;
    if (tick && (sync_reg == hist_reg[0]) && (sync_reg == hist_reg[1]))
      filt_next = sync_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg <= 2'b00;
    end else if (tick) begin
      hist_reg <= {hist_reg[0], sync_reg};
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;

  always_comb begin
    filt_next = sync_reg;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync_reg  <= 1'b0;
      filt_reg  <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync_reg  <= sync1_reg;
      filt_reg  <= filt_next;
    end
  end

  assign filt = filt_reg;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
// Core-side controller for one bank of tri-state pad cells: direction and
// output registers, synchronized (optionally debounced) inputs and
// edge-detect interrupts behind a small register bus.
// Optional feature macro: GPIO_PAD_DBNC_EN (debounce prescaler + filter).
// Ports:
//   clk_i      in   core clock
//   rst_n_i    in   asynchronous active-low reset
//   wr_en_i    in   register write strobe
//   rd_en_i    in   register read strobe
//   addr_i     in   register index
//   wdata_i    in   write data
//   rdata_o    out  registered read data, held while rd_en_i is low
//   gpio_out_o out  pad c2p
//   gpio_oe_o  out  pad c2p_en, 1 = drive
//   gpio_in_i  in   pad p2c, asynchronous
//   irq_o      out  registered level interrupt
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int PIN_NUM = 8,
  parameter int DIV_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               wr_en_i,
  input  logic               rd_en_i,
  input  logic [2:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic [PIN_NUM-1:0] gpio_out_o,
  output logic [PIN_NUM-1:0] gpio_oe_o,
  input  logic [PIN_NUM-1:0] gpio_in_i,
  output logic               irq_o
);

  logic [PIN_NUM-1:0] out_reg, oe_reg, en_reg, pend_reg, pol_reg;
  logic [PIN_NUM-1:0] out_next, oe_next, en_next, pend_next, pol_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [31:0]        rdata_reg, rdata_next;
  logic               irq_reg, irq_next;

  logic [PIN_NUM-1:0] filt, filt_next;
  logic [PIN_NUM-1:0] rise, fall, edge_set;
  logic               tick;
  logic               wr_div;

  logic [31:0] unused_wdata;
  assign unused_wdata = wdata_i;

  assign wr_div = wr_en_i && (addr_i == GPIO_DIV);

`ifdef GPIO_PAD_DBNC_EN
  // Prescaler: counts 0..DIV-1, tick on the wrap cycle. DIV=0 acts as 1.
  logic [DIV_W-1:0] cnt_reg, cnt_next, div_eff;

  always_comb begin
    div_eff  = (div_reg == '0) ? DIV_W'(1) : div_reg;
    tick     = (cnt_reg == div_eff - DIV_W'(1));
    cnt_next = tick ? '0 : cnt_reg + DIV_W'(1);
    if (wr_div)
      cnt_next = '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end
`else
  assign tick = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < PIN_NUM; gi++) begin : g_pin
      gpio_pad_dbnc u_dbnc (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .tick      (tick),
        .din       (gpio_in_i[gi]),
        .filt      (filt[gi]),
        .filt_next (filt_next[gi])
      );
    end
  endgenerate

  // Edges are taken from the value filt is about to load so that PEND and
  // irq_o rise on the same clock edge as IN.
  assign rise     = filt_next & ~filt;
  assign fall     = ~filt_next & filt;
  assign edge_set = (rise & pol_reg) | (fall & ~pol_reg);

  always_comb begin
    out_next = out_reg;
    oe_next  = oe_reg;
    en_next  = en_reg;
    pol_next = pol_reg;
    div_next = div_reg;
    pend_next = pend_reg;
    if (wr_en_i) begin
      case (addr_i)
        GPIO_OUT:      out_next  = wdata_i[PIN_NUM-1:0];
        GPIO_OE:       oe_next   = wdata_i[PIN_NUM-1:0];
        GPIO_IRQ_EN:   en_next   = wdata_i[PIN_NUM-1:0];
        GPIO_IRQ_POL:  pol_next  = wdata_i[PIN_NUM-1:0];
        GPIO_DIV:      div_next  = wdata_i[DIV_W-1:0];
        GPIO_IRQ_PEND: pend_next = pend_reg & ~wdata_i[PIN_NUM-1:0];
        default: ;
      endcase
    end
    // A new edge beats a simultaneous write-1-to-clear.
    pend_next = pend_next | edge_set;
    irq_next  = |(pend_next & en_next);
  end

  // Read mux uses current register values, so a same-cycle write is not seen.
  always_comb begin
    rdata_next = rdata_reg;
    if (rd_en_i) begin
      rdata_next = '0;
      case (addr_i)
        GPIO_OUT:      rdata_next[PIN_NUM-1:0] = out_reg;
        GPIO_OE:       rdata_next[PIN_NUM-1:0] = oe_reg;
        GPIO_IN:       rdata_next[PIN_NUM-1:0] = filt;
        GPIO_IRQ_EN:   rdata_next[PIN_NUM-1:0] = en_reg;
        GPIO_IRQ_PEND: rdata_next[PIN_NUM-1:0] = pend_reg;
        GPIO_IRQ_POL:  rdata_next[PIN_NUM-1:0] = pol_reg;
        GPIO_DIV:      rdata_next[DIV_W-1:0]   = div_reg;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_reg   <= '0;
      oe_reg    <= '0;
      en_reg    <= '0;
      pol_reg   <= '0;
      pend_reg  <= '0;
      div_reg   <= DIV_W'(GPIO_DIV_RST);
      rdata_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      out_reg   <= out_next;
      oe_reg    <= oe_next;
      en_reg    <= en_next;
      pol_reg   <= pol_next;
      pend_reg  <= pend_next;
      div_reg   <= div_next;
      rdata_reg <= rdata_next;
      irq_reg   <= irq_next;
    end
  end

  assign gpio_out_o = out_reg;
  assign gpio_oe_o  = oe_reg;
  assign rdata_o    = rdata_reg;
  assign irq_o      = irq_reg;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl
// Directed-vector bench for gpio_pad_ctrl. Inputs change on the falling
// edge, outputs are sampled on the falling edge. With GPIO_PAD_DBNC_EN
// defined (DIV=1 after reset) the input path has two extra edges of latency
// and the debounce vectors are added.
module tb_gpio_pad_ctrl;

  localparam int PIN_NUM = 8;
  localparam int DIV_W   = 16;
`ifdef GPIO_PAD_DBNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic               rd_en = 1'b0;
  logic [2:0]         addr = 3'd0;
  logic [31:0]        wdata = 32'd0;
  logic [31:0]        rdata;
  logic [PIN_NUM-1:0] gpio_out;
  logic [PIN_NUM-1:0] gpio_oe;
  logic [PIN_NUM-1:0] gpio_in = '0;
  logic               irq;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.PIN_NUM(PIN_NUM), .DIV_W(DIV_W)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wr_en_i    (wr_en),
    .rd_en_i    (rd_en),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .gpio_out_o (gpio_out),
    .gpio_oe_o  (gpio_oe),
    .gpio_in_i  (gpio_in),
    .irq_o      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] r;

  initial begin
    // Reset state
    #12;
    chk("rst_oe", 32'(gpio_oe), 32'h0);
    chk("rst_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd6, r); chk("div_rst", r, 32'h1);
    rd(3'd7, r); chk("reserved", r, 32'h0);

    // Direction and output
    wr(3'd1, 32'hFF); chk("oe_ff", 32'(gpio_oe), 32'hFF);
    wr(3'd0, 32'hA5); chk("out_a5", 32'(gpio_out), 32'hA5);

    // Same-cycle read and write returns the old value; rdata then holds
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 3'd0; wdata = 32'h3C;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdwr_old", rdata, 32'hA5);
    chk("rdwr_out", 32'(gpio_out), 32'h3C);
    cyc(2);
    chk("rdata_hold", rdata, 32'hA5);
    rd(3'd0, r); chk("out_rd", r, 32'h3C);

    // Sync latency on pin 3, rising polarity, enabled
    wr(3'd5, 32'h08);
    wr(3'd3, 32'h08);
    gpio_in[3] = 1'b1;
    cyc(2 + EXTRA);
    chk("lat_irq_early", 32'(irq), 32'h0);
    cyc(1);
    chk("lat_irq", 32'(irq), 32'h1);
    rd(3'd2, r); chk("lat_in", r, 32'h08);
    rd(3'd4, r); chk("lat_pend", r, 32'h08);
    wr(3'd4, 32'h08); chk("w1c3_irq", 32'(irq), 32'h0);
    rd(3'd4, r); chk("w1c3_pend", r, 32'h0);

    // Falling polarity on pin 0
    wr(3'd3, 32'h01);
    gpio_in[0] = 1'b1;
    cyc(8);
    rd(3'd4, r); chk("pol0_rise_ignored", r, 32'h0);
    gpio_in[0] = 1'b0;
    cyc(8);
    chk("pol0_irq", 32'(irq), 32'h1);
    rd(3'd4, r); chk("pol0_pend", r, 32'h01);
    wr(3'd4, 32'h01); chk("w1c0_irq", 32'(irq), 32'h0);
    rd(3'd4, r); chk("w1c0_pend", r, 32'h0);

    // W1C landing on the same edge as a new falling edge: set wins
    gpio_in[0] = 1'b1;
    cyc(8);
    gpio_in[0] = 1'b0;
    cyc(2 + EXTRA);
    wr_en = 1'b1; addr = 3'd4; wdata = 32'h01;
    @(negedge clk);
    wr_en = 1'b0;
    chk("race_irq", 32'(irq), 32'h1);
    rd(3'd4, r); chk("race_pend", r, 32'h01);
    wr(3'd4, 32'h01);
    wr(3'd3, 32'h00);

    // Masked pending on pin 5
    wr(3'd5, 32'h20);
    gpio_in[5] = 1'b1;
    cyc(8);
    chk("mask_irq", 32'(irq), 32'h0);
    rd(3'd4, r); chk("mask_pend", r, 32'h20);
    wr(3'd3, 32'h20); chk("unmask_irq", 32'(irq), 32'h1);

`ifdef GPIO_PAD_DBNC_EN
    // Debounce with DIV=4 on pin 1
    wr(3'd3, 32'h00);
    wr(3'd4, 32'hFF);
    wr(3'd5, 32'h02);
    wr(3'd6, 32'h4);
    rd(3'd6, r); chk("div_4", r, 32'h4);
    gpio_in[1] = 1'b1;
    cyc(6);
    gpio_in[1] = 1'b0;
    cyc(20);
    rd(3'd2, r); chk("glitch_in", r, 32'h28);
    rd(3'd4, r); chk("glitch_pend", r, 32'h0);
    gpio_in[1] = 1'b1;
    cyc(20);
    rd(3'd2, r); chk("stable_in", r, 32'h2A);
    rd(3'd4, r); chk("stable_pend", r, 32'h02);
    wr(3'd3, 32'h02); chk("stable_irq", 32'(irq), 32'h1);
    cyc(1);
`endif

    // Asynchronous reset in the middle of operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_out", 32'(gpio_out), 32'h0);
    chk("arst_oe", 32'(gpio_oe), 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(3'd6, r); chk("arst_div", r, 32'h1);
    rd(3'd4, r); chk("arst_pend", r, 32'h0);
    rd(3'd3, r); chk("arst_en", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
- Core-side controller for a bank of tri-state pad cells. Drives each pad's c2p/c2p_en and samples its p2c.
- Adds per-pin direction and output registers, an input synchronizer and optional glitch filter, and edge-detect interrupts.
- Sits between the peripheral register bus and the tri-state pad ring: one instance per GPIO bank.

Parameters:
- PIN_NUM, 8: number of pins in the bank; range 1..32.
- DIV_W, 16: width of the debounce prescaler divider.

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  asynchronous active-low reset.
- wr_en_i  in  1  register write strobe, single cycle.
- rd_en_i  in  1  register read strobe, single cycle.
- addr_i  in  3  register index.
- wdata_i  in  32  write data; only [PIN_NUM-1:0] is used, except DIV, which uses [DIV_W-1:0].
- rdata_o  out  32  read data; valid the cycle after rd_en_i; unused bits are 0.
- gpio_out_o  out  PIN_NUM  to the pad's c2p.
- gpio_oe_o  out  PIN_NUM  to the pad's c2p_en; 1 = drive.
- gpio_in_i  in  PIN_NUM  from the pad's p2c; asynchronous.
- irq_o  out  1  registered level interrupt.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_n_i is asynchronous assert, active-low. All flops clear on reset.
- Reset values: gpio_out_o=0, gpio_oe_o=0 (all pins input), rdata_o=0, irq_o=0, all registers 0. The exception is DIV, which resets to 1.
- Register map (addr_i):
  - 0 OUT: rw.
  - 1 OE: rw.
  - 2 IN: ro, filtered input value.
  - 3 IRQ_EN: rw.
  - 4 IRQ_PEND: write-1-to-clear; reads return the pending bits.
  - 5 IRQ_POL: rw; 1 = rising edge, 0 = falling edge.
  - 6 DIV: rw.
  - 7: reserved; reads 0, writes ignored.
- Writes take effect on the next clock edge. gpio_out_o and gpio_oe_o are the OUT/OE flops directly, so there is no combinational path from wdata_i.
- Reads: rdata_o is registered. When rd_en_i is low, rdata_o holds its last value.
- wr_en_i and rd_en_i in the same cycle: the read returns the pre-write value.
- Input path: 2-flop synchronizer per pin, producing sync.
- Filtered value filt:
  - Without debounce, filt = sync delayed one cycle.
  - With debounce, see Optional Feature.
- Edge detect: filt_q is the previous filt.
  - Rising edge = filt & ~filt_q; falling edge = ~filt & filt_q.
  - A pin's edge sets PEND[i] when it matches IRQ_POL[i]. PEND sets regardless of IRQ_EN.
- Same-cycle set and W1C clear on one PEND bit: set wins.
- irq_o is registered |(PEND & IRQ_EN). It drops the cycle after the last enabled pending bit clears.
- Latency, no debounce: gpio_in_i edge → IN readable, PEND set, and irq_o high all at clock edge 3.
- Output pins (OE=1) still sample gpio_in_i, so IN reflects the pad value (loopback).

Optional Feature:
- Macro: GPIO_PAD_DBNC_EN.
- When defined:
  - A prescaler counts 0..DIV-1 and emits a one-cycle tick at wrap. DIV=0 is treated as 1.
  - Per pin, a 2-bit history shifts sync in on each tick.
  - filt updates to sync only when sync equals both history bits, i.e. stable for 3 consecutive ticks; otherwise filt holds.
  - A write to DIV restarts the prescaler at 0. History is preserved.
- When undefined:
  - Prescaler and filter are absent; filt = sync delayed one cycle.
  - DIV register remains readable/writable but has no effect.

Decomposition:
- Package gpio_pad_pkg holds:
  - register index localparams: GPIO_OUT=0, GPIO_OE=1, GPIO_IN=2, GPIO_IRQ_EN=3, GPIO_IRQ_PEND=4, GPIO_IRQ_POL=5, GPIO_DIV=6.
  - the DIV reset value constant.
- One natural sub-module: gpio_pad_dbnc. It contains the per-pin synchronizer, history and filt flop, driven by a shared tick input. It is instantiated PIN_NUM times via generate.

Test Plan:
- Reset and direction: after reset, gpio_oe_o=0 and gpio_out_o=0. Write OE=0xFF then OUT=0xA5 → gpio_oe_o=0xFF, gpio_out_o=0xA5 one cycle after the write.
- Sync latency: DBNC off, gpio_in_i[3] 0→1 → IN reads 0x08 from edge 3. With IRQ_EN[3]=1 and POL[3]=1 → PEND=0x08 and irq_o=1 at edge 3.
- Polarity and W1C: POL[0]=0, pin 0 falls → PEND[0]=1.
  - Write PEND=0x01 → PEND=0 and irq_o=0 one cycle later.
  - A new falling edge landing on the same cycle as the W1C → PEND[0] stays 1.
- Masked pending: IRQ_EN=0, pin 5 rises → PEND=0x20 and irq_o=0. Then write IRQ_EN=0x20 → irq_o=1 on the next cycle.
- Debounce (GPIO_PAD_DBNC_EN, DIV=4):
  - A 6-cycle glitch on pin 1 → IN unchanged and no PEND.
  - A level held 12+ cycles (3 ticks) → IN[1] updates and PEND sets.
- Reset mid-operation: assert rst_n_i while irq_o=1 and the prescaler is mid-count → irq_o, PEND and OUT clear immediately and asynchronously; DIV returns to 1.
